// File: rtl/shift_array_flow_ctrl.sv
// Valid/ready shift-register pipeline whose words advance only on shifts,
// with a flush mode that pushes bubbles in until every live word has left.
module shift_array_flow_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT_WIDTH-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         out_data,
  input  logic                         flush,
  output logic                         flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state, state_next;
  logic [BIT_WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0]     vld, vld_next;
  logic [OCC_W-1:0]     occ_next;
  logic                 can_shift, accept, shift, done_next;

  assign can_shift = !vld[DEPTH-1] | out_ready;
  assign in_ready  = (state == RUN) & can_shift;
  assign accept    = in_valid & in_ready;
  assign shift     = accept | ((state == FLUSH) & can_shift);
  assign out_valid = vld[DEPTH-1];
  assign out_data  = stage[DEPTH-1];

  // A consumed output word with no shift just drops its live flag in place.
  always_comb begin
    vld_next = vld;
    if (shift) begin
      vld_next = {vld[DEPTH-2:0], accept};
    end else if (vld[DEPTH-1] & out_ready) begin
      vld_next[DEPTH-1] = 1'b0;
    end
  end

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(vld_next[i]);
    end
  end

  // Flush decisions look at post-update occupancy so a coincident accept is drained.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      RUN: begin
        if (flush) begin
          if (occ_next == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (vld_next == '0) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      vld        <= '0;
      occupancy  <= '0;
      flush_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      state      <= state_next;
      vld        <= vld_next;
      occupancy  <= occ_next;
      flush_done <= done_next;
      if (shift) begin
        stage[0] <= accept ? in_data : '0;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_array_flow_ctrl.sv
// Bench for shift_array_flow_ctrl: directed scenarios plus a random run, all
// checked against a queue-of-words model where each word carries its stage position.
module tb_shift_array_flow_ctrl;

  localparam int BW    = 8;
  localparam int D     = 4;
  localparam int OCC_W = $clog2(D+1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BW-1:0]    out_data;
  logic             flush = 1'b0;
  logic             flush_done;
  logic [OCC_W-1:0] occupancy;

  int vectors = 0;
  int miscompares = 0;

  shift_array_flow_ctrl #(.BIT_WIDTH(BW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .flush_done(flush_done),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: live words oldest-first, each with the stage it sits in.
  typedef struct {
    logic [BW-1:0] data;
    int            pos;
  } word_t;

  word_t mq[$];
  bit    m_flushing = 1'b0;
  bit    m_done = 1'b0;

  function automatic bit m_out_valid();
    return (mq.size() > 0) && (mq[0].pos == D-1);
  endfunction

  function automatic logic [BW-1:0] m_out_data();
    return (mq.size() > 0) ? mq[0].data : '0;
  endfunction

  function automatic bit m_in_ready();
    return !m_flushing && (!m_out_valid() || out_ready);
  endfunction

  task automatic set_in(input bit iv, input logic [BW-1:0] d, input bit orr, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick();
    bit    ov, acc, sh;
    word_t w;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_flushing = 1'b0;
      m_done     = 1'b0;
    end else begin
      ov  = m_out_valid();
      acc = in_valid && m_in_ready();
      sh  = acc || (m_flushing && (!ov || out_ready));
      if (sh) begin
        if (ov) void'(mq.pop_front());
        foreach (mq[i]) mq[i].pos = mq[i].pos + 1;
        if (acc) begin
          w.data = in_data;
          w.pos  = 0;
          mq.push_back(w);
        end
      end else if (ov && out_ready) begin
        void'(mq.pop_front());
      end
      m_done = 1'b0;
      if (!m_flushing && flush) begin
        if (mq.size() == 0) m_done = 1'b1;
        else m_flushing = 1'b1;
      end else if (m_flushing && mq.size() == 0) begin
        m_flushing = 1'b0;
        m_done     = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(0, '0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++;
    if (occupancy !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_occupancy: got %0d want 0", occupancy); end
    vectors++;
    if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flush_done: got %b want 0", flush_done); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      set_in(1, BW'(k), 1, 0);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready); end
      tick();
      vectors++;
      if (out_valid !== (k >= 4)) begin miscompares++; $display("[TB] FAIL stream_out_valid k=%0d: got %b want %b", k, out_valid, k >= 4); end
      if (k >= 4) begin
        vectors++;
        if (out_data !== BW'(k-3)) begin miscompares++; $display("[TB] FAIL stream_out_data k=%0d: got %h want %h", k, out_data, BW'(k-3)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] got[$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 8'h11 + BW'(k), 0, 0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      set_in(1, 8'h99, 0, 0);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready); end
      vectors++;
      if (out_data !== 8'h11 || out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_out c=%0d: got %b/%h want 1/11", c, out_valid, out_data); end
      vectors++;
      if (occupancy !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_occupancy c=%0d: got %0d want 4", c, occupancy); end
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      set_in(0, '0, 1, c == 0);
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("[TB] FAIL bp_count: got %0d words want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      vectors++;
      if (got[k] !== 8'h11 + BW'(k)) begin miscompares++; $display("[TB] FAIL bp_order k=%0d: got %h want %h", k, got[k], 8'h11 + BW'(k)); end
    end
  endtask

  task automatic test_drain();
    logic [BW-1:0] got[$];
    int dones = 0;
    do_reset();
    set_in(1, 8'hA1, 1, 0); tick();
    set_in(1, 8'hA2, 1, 0); tick();
    for (int c = 0; c < 12; c++) begin
      set_in(m_flushing, 8'hEE, 1, c == 0);
      #1;
      if (m_flushing) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_in_ready c=%0d: got %b want 0", c, in_ready); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (flush_done) dones++;
      tick();
    end
    vectors++;
    if (got.size() != 2 || got[0] !== 8'hA1 || got[1] !== 8'hA2) begin
      miscompares++; $display("[TB] FAIL drain_words: got %0d words (first %h) want A1,A2", got.size(), got.size() > 0 ? got[0] : 8'h00);
    end
    vectors++;
    if (dones != 1) begin miscompares++; $display("[TB] FAIL drain_done_pulses: got %0d want 1", dones); end
    vectors++;
    if (occupancy !== 3'd0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_end: got occ %0d rdy %b want 0/1", occupancy, in_ready); end
  endtask

  task automatic test_empty_flush();
    do_reset();
    set_in(0, '0, 1, 1);
    tick();
    set_in(0, '0, 1, 0);
    #1;
    vectors++;
    if (flush_done !== 1'b1) begin miscompares++; $display("[TB] FAIL empty_flush_done: got %b want 1", flush_done); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL empty_flush_in_ready: got %b want 1", in_ready); end
    tick();
    vectors++;
    if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_flush_single: got %b want 0", flush_done); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 8'hC1 + BW'(k), 0, 0);
      tick();
    end
    set_in(0, '0, 0, 1); tick();
    set_in(0, '0, 0, 0); tick();
    tick();
    vectors++;
    if (occupancy !== 3'd3 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midflush_pre: got occ %0d rdy %b want 3/0", occupancy, in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midflush_clear: got occ %0d ov %b want 0/0", occupancy, out_valid); end
    vectors++;
    if (in_ready !== 1'b1 || flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midflush_ready: got rdy %b done %b want 1/0", in_ready, flush_done); end
    tick();
    vectors++;
    if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midflush_no_done: got %b want 0", flush_done); end
  endtask

  task automatic test_simultaneous();
    int got_at = -1;
    int done_at = -1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_in(c == 0, 8'h5A, 1, c == 0);
      #1;
      if (out_valid && out_data === 8'h5A && got_at < 0) got_at = c;
      if (flush_done && done_at < 0) done_at = c;
      tick();
    end
    vectors++;
    if (got_at < 0 || done_at < 0 || got_at >= done_at) begin
      miscompares++; $display("[TB] FAIL simul_order: got word@%0d done@%0d want word before done", got_at, done_at);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      #1;
      vectors++;
      if (in_ready !== m_in_ready()) begin miscompares++; $display("[TB] FAIL rand_in_ready c=%0d: got %b want %b", c, in_ready, m_in_ready()); end
      vectors++;
      if (out_valid !== m_out_valid()) begin miscompares++; $display("[TB] FAIL rand_out_valid c=%0d: got %b want %b", c, out_valid, m_out_valid()); end
      if (m_out_valid()) begin
        vectors++;
        if (out_data !== m_out_data()) begin miscompares++; $display("[TB] FAIL rand_out_data c=%0d: got %h want %h", c, out_data, m_out_data()); end
      end
      vectors++;
      if (occupancy !== OCC_W'(mq.size())) begin miscompares++; $display("[TB] FAIL rand_occupancy c=%0d: got %0d want %0d", c, occupancy, mq.size()); end
      vectors++;
      if (flush_done !== m_done) begin miscompares++; $display("[TB] FAIL rand_flush_done c=%0d: got %b want %b", c, flush_done, m_done); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_empty_flush();
    test_reset_mid_flush();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
